// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift request scheduler and its arbiter.
package shift_ctrl_pkg;

  localparam int unsigned MaxStep     = 7;
  localparam int unsigned SelW        = 3;
  localparam int unsigned AmtWDefault = 4;
  localparam int unsigned IdW         = 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; ptr_q=0 favours req[0] on contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant, favour whichever requester was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shift_req_scheduler.sv
// Shares one 8-bit left shifter between two requesters, splitting large shifts
// into registered passes of at most MaxStep and returning tagged responses.
module shift_req_scheduler
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned AMT_W = AmtWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [7:0]       sh_a,
  output logic             sh_s2,
  output logic             sh_s1,
  output logic             sh_s0,
  input  logic [7:0]       sh_o
);

  state_e             state_q, state_d;
  logic [7:0]         work_q, work_d;
  logic [AMT_W-1:0]   rem_q, rem_d, rem_nxt;
  logic [IdW-1:0]     id_q, id_d;
  logic [1:0]         arb_req, gnt;
  logic               accept;
  logic [SelW-1:0]    step, sel;

  assign arb_req = {req1_valid, req0_valid} & {2{state_q == StIdle}};
  assign accept  = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    if (rem_q >= AMT_W'(MaxStep)) begin
      step = SelW'(MaxStep);
    end else begin
      step = rem_q[SelW-1:0];
    end
  end

  assign rem_nxt = rem_q - AMT_W'(step);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          work_d  = gnt[1] ? req1_data : req0_data;
          rem_d   = gnt[1] ? req1_amt : req0_amt;
          id_d    = gnt[1];
          state_d = StShift;
        end
      end
      StShift: begin
        // Amount 0 still takes one pass, so the exit test uses the updated rem.
        work_d = sh_o;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
    end
  end

  assign sel       = (state_q == StShift) ? step : '0;
  assign sh_a      = (state_q == StShift) ? work_q : 8'h00;
  assign {sh_s2, sh_s1, sh_s0} = sel;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = (state_q == StResp) ? work_q : 8'h00;
  assign rsp_id    = (state_q == StResp) ? id_q[0] : 1'b0;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_req_scheduler.sv
// Directed bench: table of single commands plus arbitration, backpressure and reset sequences.
module tb_shift_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [3:0] req0_amt, req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data, sh_a, sh_o;
  logic       sh_s2, sh_s1, sh_s0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Reference shifter honouring the sh_o contract.
  assign sh_o = sh_a << {sh_s2, sh_s1, sh_s0};

  shift_req_scheduler #(.AMT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .sh_a       (sh_a),
    .sh_s2      (sh_s2),
    .sh_s1      (sh_s1),
    .sh_s0      (sh_s0),
    .sh_o       (sh_o)
  );

  typedef struct {
    logic           id;
    logic [7:0]     data;
    logic [3:0]     amt;
    int             passes;
    logic [2:0][2:0] sels;  // sels[0] is the first pass
    logic [7:0]     exp;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [7:0] d, input logic [3:0] a);
    if (id) begin
      req1_valid = v; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = v; req0_data = d; req0_amt = a;
    end
  endtask

  // Waits (bounded) at negedges until rsp_valid; returns cycles waited.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy, sh_a,
            sh_s2, sh_s1, sh_s0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pass, seen;
    vecs[0] = '{1'b0, 8'hB5, 4'd3,  1, {3'd0, 3'd0, 3'd3}, 8'hA8};
    vecs[1] = '{1'b1, 8'h01, 4'd15, 3, {3'd1, 3'd7, 3'd7}, 8'h00};
    vecs[2] = '{1'b0, 8'h01, 4'd9,  2, {3'd0, 3'd2, 3'd7}, 8'h00};
    vecs[3] = '{1'b0, 8'h5A, 4'd0,  1, {3'd0, 3'd0, 3'd0}, 8'h5A};
    vecs[4] = '{1'b1, 8'h0F, 4'd4,  1, {3'd0, 3'd0, 3'd4}, 8'hF0};
    vecs[5] = '{1'b1, 8'h81, 4'd7,  1, {3'd0, 3'd0, 3'd7}, 8'h80};
    vecs[6] = '{1'b0, 8'hFF, 4'd8,  2, {3'd0, 3'd1, 3'd7}, 8'h00};
    vecs[7] = '{1'b1, 8'hC3, 4'd14, 2, {3'd0, 3'd7, 3'd7}, 8'h00};

    rst_n = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;

    // Table of single-requester commands.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].id, 1'b1, vecs[i].data, vecs[i].amt);
      #1;
      check("grant", {30'd0, req1_ready, req0_ready}, vecs[i].id ? 32'd2 : 32'd1);
      @(negedge clk);
      drive(vecs[i].id, 1'b0, 8'h00, 4'd0);
      pass = 0; cyc = 1;
      while (!rsp_valid && cyc < 20) begin
        if (pass < 3) check("sel", {29'd0, sh_s2, sh_s1, sh_s0}, {29'd0, vecs[i].sels[pass]});
        pass++;
        @(negedge clk);
        cyc++;
      end
      check("latency", cyc, vecs[i].passes + 1);
      check("passes", pass, vecs[i].passes);
      check("rsp_data", {24'd0, rsp_data}, {24'd0, vecs[i].exp});
      check("rsp_id", {31'd0, rsp_id}, {31'd0, vecs[i].id});
      check("busy_resp", {31'd0, busy}, 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", {30'd0, rsp_valid, busy}, 32'd0);
    end

    // Arbitration from reset with both requesters held valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h03, 4'd1);
    drive(1'b1, 1'b1, 8'h81, 4'd2);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", {30'd0, req1_ready, req0_ready}, (k % 2) ? 32'd2 : 32'd1);
      @(negedge clk);
      wait_rsp(cyc);
      check("rr_lat", cyc, 1);
      check("rr_data", {24'd0, rsp_data}, (k % 2) ? 32'h04 : 32'h06);
      check("rr_id", {31'd0, rsp_id}, k % 2);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    @(negedge clk);

    // Backpressure: hold RESP for 5 cycles with req1 waiting.
    drive(1'b0, 1'b1, 8'hC3, 4'd2);
    #1;
    check("bp_grant", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    wait_rsp(cyc);
    drive(1'b1, 1'b1, 8'h77, 4'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold", {rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data},
            {5'b10100, 8'h0C});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_done", {29'd0, rsp_valid, busy, req1_ready}, 32'd1);
    // Dropping valid before accept must leave no trace.
    drive(1'b1, 1'b0, 8'h00, 4'd0);
    @(negedge clk);
    check("drop_no_effect", {31'd0, busy}, 32'd0);

    // Reset on the second SHIFT cycle of an amt-15 command.
    drive(1'b0, 1'b1, 8'h01, 4'd15);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 4'd0);
    @(negedge clk);
    check("mid_sel", {29'd0, sh_s2, sh_s1, sh_s0}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("no_rsp_after_reset", seen, 0);
    drive(1'b0, 1'b1, 8'h11, 4'd1);
    drive(1'b1, 1'b1, 8'h22, 4'd1);
    #1;
    check("post_reset_grant", {30'd0, req1_ready, req0_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
